// File: rtl/serial_word_collector.sv
// serial_word_collector: reassembles start/data/stop serial frames into words on a valid/ready output.
// Define PARITY_CHECK_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_word_collector #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_din,
  input  logic             s_din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             frame_err,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic last, done, good;
  assign last = cnt == CW'(WIDTH - 1);
  assign done = s_din_vld && state == STOP;
`ifdef PARITY_CHECK_EN
  logic par_err;
  assign good = s_din && !par_err;
`else
  assign good = s_din;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (s_din_vld)
      case (state)
        IDLE:    next = s_din ? IDLE : DATA;
`ifdef PARITY_CHECK_EN
        DATA:    next = last ? PARITY : DATA;
        PARITY:  next = STOP;
`else
        DATA:    next = last ? STOP : DATA;
`endif
        default: next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= '0;
      sh        <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err   <= 1'b0;
`endif
    end else begin
      if (s_din_vld && state == IDLE && !s_din) cnt <= '0;
      if (s_din_vld && state == DATA) begin
        sh  <= MSB_FIRST ? {sh[WIDTH-2:0], s_din} : {s_din, sh[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
`ifdef PARITY_CHECK_EN
      if (s_din_vld && state == IDLE && !s_din) par_err <= 1'b0;
      if (s_din_vld && state == PARITY) par_err <= s_din ^ (^sh);
`endif
      // a word accepted in the same cycle frees the slot for the new one
      if (done && good && (!dout_vld || dout_rdy)) begin
        dout     <= sh;
        dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) dout_vld <= 1'b0;
      overrun   <= done && good && dout_vld && !dout_rdy;
      frame_err <= done && !good;
    end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: randomized frames against a word-level model of delivery and handshake.
module tb_serial_word_collector;
  logic clk = 0, rst = 0, s_din = 0, s_din_vld = 0, dout_rdy = 0;
  logic [3:0] dout;
  logic dout_vld, frame_err, overrun;
  int n_cmp = 0, n_bad = 0, rdy_mode = 1;
  logic [3:0] exp_dout = 0;
  logic exp_vld = 0;

  serial_word_collector dut (
    .clk(clk), .rst(rst), .s_din(s_din), .s_din_vld(s_din_vld), .dout(dout),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ev: 0 no frame end, 1 good frame ends holding w, 2 bad frame ends
  task automatic tick(input logic d, input logic v, input int ev, input logic [3:0] w);
    logic r, fe, ov;
    r = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    s_din = d; s_din_vld = v; dout_rdy = r;
    @(posedge clk); #1;
    s_din_vld = 0;
    fe = 0; ov = 0;
    if (ev == 2) fe = 1;
    if (ev == 1 && exp_vld && !r) ov = 1;
    else if (ev == 1) begin exp_dout = w; exp_vld = 1; end
    else if (exp_vld && r) exp_vld = 0;
    check("dout_vld", 32'(dout_vld), 32'(exp_vld));
    check("dout", 32'(dout), 32'(exp_dout));
    check("frame_err", 32'(frame_err), 32'(fe));
    check("overrun", 32'(overrun), 32'(ov));
  endtask

  task automatic send_frame(input logic [3:0] w, input logic stop, input logic par_bad, input bit gaps);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 4; i++) q.push_back(w[i]);
`ifdef PARITY_CHECK_EN
    q.push_back((^w) ^ par_bad);
`endif
    q.push_back(stop);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick(1'($urandom_range(0, 1)), 1'b0, 0, w);
      tick(q[i], 1'b1, i == q.size() - 1 ? ((stop && !par_bad) ? 1 : 2) : 0, w);
    end
  endtask

  task automatic reset_check();
    check("rst dout", 32'(dout), 0);
    check("rst dout_vld", 32'(dout_vld), 0);
    check("rst frame_err", 32'(frame_err), 0);
    check("rst overrun", 32'(overrun), 0);
  endtask

  initial begin
    #2 reset_check();
    @(posedge clk); #1 rst = 1;
    // reset mid-frame after two data bits, then a clean 4'h5
    rdy_mode = 1;
    tick(0, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    rst = 0; #2 reset_check();
    exp_vld = 0; exp_dout = 0;
    @(posedge clk); #1 rst = 1;
    send_frame(4'h5, 1, 0, 0);
    check("t1 word", 32'(dout), 32'h5);
    tick(1, 0, 0, 0);
    send_frame(4'hB, 1, 0, 0);
    check("t2 word", 32'(dout), 32'hB);
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    send_frame(4'h2, 0, 0, 0);
    check("t3 no vld", 32'(dout_vld), 0);
    send_frame(4'h3, 1, 0, 0);
    check("t3 word", 32'(dout), 32'h3);
    tick(1, 0, 0, 0);
    rdy_mode = 0;
    send_frame(4'hA, 1, 0, 0);
    send_frame(4'h6, 1, 0, 0);
    check("t4 held", 32'(dout), 32'hA);
    rdy_mode = 1;
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    send_frame(4'hC, 1, 0, 1);
    check("t5 word", 32'(dout), 32'hC);
`ifdef PARITY_CHECK_EN
    tick(1, 0, 0, 0);
    send_frame(4'hB, 1, 0, 0);
    check("t6 good parity", 32'(dout), 32'hB);
    tick(1, 0, 0, 0);
    send_frame(4'hB, 1, 1, 0);
    check("t6 bad parity", 32'(dout_vld), 0);
`endif
    rdy_mode = 2;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) tick(1, 1, 0, 0);
`ifdef PARITY_CHECK_EN
      send_frame(4'($urandom), 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
`else
      send_frame(4'($urandom), 1'($urandom_range(0, 5) != 0), 1'b0, 1'($urandom_range(0, 1)));
`endif
    end
    rdy_mode = 1;
    repeat (3) tick(1, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
